frog_control_hub: RTL and testbench
===================================

Name: frog_control_hub

Overview:
- Parametrised replacement for the hand-wired frog-select / arrow-key glue at the top level, scaled from three frogs to NUM_FROGS.
- Decodes the USB keycode into a latched active-frog selection and per-frame one-shot move pulses, with press-and-hold auto-repeat.
- Auto-advances the selection when the active frog dies or reaches home.
- Muxes the active frog's position out to the car_row and lilypad_row collision logic.

Parameters:
- NUM_FROGS, 3, number of frog instances (1..8).
- COORD_W, 11, coordinate width.
- KEY_W, 16, keycode width.
- SEL_KEY_BASE, 16'h59, keycode that selects frog 0; frog k is selected by SEL_KEY_BASE+k.
- REPEAT_DELAY, 20, frames a direction key must be held before the first repeat; 0 disables repeat.
- REPEAT_RATE, 6, frames between repeats once repeating (minimum 1).

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset  in  1  synchronous, active-high reset.
- frame_vs  in  1  raw VGA vertical sync; sampled internally.
- keycode  in  KEY_W  current USB keycode; 0 means no key.
- frog_x  in  NUM_FROGS x COORD_W  top-left X of each frog.
- frog_y  in  NUM_FROGS x COORD_W  top-left Y of each frog.
- frog_dead  in  NUM_FROGS  frog k has been killed (level).
- frog_home  in  NUM_FROGS  frog k has reached the goal row (level).
- active_onehot  out  NUM_FROGS  one-hot selected frog; all zero when none is selected.
- active_idx  out  $clog2(NUM_FROGS)  index of the selected frog.
- sel_valid  out  1  a frog is selected.
- cur_x  out  COORD_W  X of the selected frog; 0 when sel_valid=0.
- cur_y  out  COORD_W  Y of the selected frog; 0 when sel_valid=0.
- move_up, move_down, move_left, move_right  out  1 each  one-Clk move pulses.
- last_dir  out  2  direction of the most recent move pulse (dir_t).

Behaviour:
- Clock and reset:
  - Single clock domain, Clk.
  - Reset is synchronous and active-high.
  - Reset clears: the two-flop frame_vs synchroniser, the keycode register, selection, repeat FSM and frame counter.
- Reset values: active_onehot=0, active_idx=0, sel_valid=0, cur_x=0, cur_y=0, all move_*=0, last_dir=DIR_UP.
- Frame event:
  - frame_evt = vs_s1 & ~vs_s2 after the two-flop synchroniser.
  - Exactly one Clk-cycle pulse per vsync rising edge.
- Keycode path:
  - keycode is registered once (key_q). All decode uses key_q.
  - Compare is on the full KEY_W bits; unlisted codes are ignored.
- Selection:
  - key_q == SEL_KEY_BASE+k, with k < NUM_FROGS, and frog k not dead and not home → select k.
  - Latency: active_idx, active_onehot and sel_valid update 2 Clk after keycode is presented.
  - The selection persists when the key is released.
  - A select of an ineligible frog (dead or home) is ignored.
- Auto-advance:
  - Triggered when the active frog is sampled dead or home.
  - Next cycle selects the lowest eligible index above active_idx, wrapping modulo NUM_FROGS.
  - If no frog is eligible: sel_valid=0 and active_onehot=0.
  - Auto-advance has priority over a select key presented in the same cycle.
- Position mux: cur_x and cur_y are registered from frog_x/frog_y[active_idx], so they lag the selection by 1 Clk.
- Repeat FSM (sub-module key_repeat), states IDLE, DELAY, REPEAT:
  - Direction decode: 16'h52 up, 16'h51 down, 16'h50 left, 16'h4F right. Any other key_q value means no direction.
  - IDLE: on frame_evt with a direction held and sel_valid=1 → pulse that direction, load cnt=REPEAT_DELAY-1, go to DELAY. If REPEAT_DELAY=0, go to DELAY and never leave it until release.
  - DELAY: on each frame_evt, if cnt==0 → pulse, load cnt=REPEAT_RATE-1, go to REPEAT; else decrement.
  - REPEAT: on each frame_evt, if cnt==0 → pulse and reload REPEAT_RATE-1; else decrement.
  - Any state: direction released or changed (evaluated every Clk) → IDLE immediately with cnt cleared. A changed direction therefore pulses on the next frame_evt.
- Move pulses:
  - Only ever asserted in a frame_evt cycle; at most one move_* high per cycle.
  - Suppressed entirely while sel_valid=0. The FSM still tracks key state.
  - A selection change does not reset the FSM.
- last_dir updates on every emitted pulse and holds otherwise.
- Reset asserted mid-hold: all outputs return to reset values the next cycle. After reset, a still-held key is treated as a fresh press.

Decomposition:
- Package frogger_pkg holds:
  - dir_t enum: DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3.
  - rpt_state_t enum: IDLE, DELAY, REPEAT.
  - Localparams KEY_UP=16'h52, KEY_DOWN=16'h51, KEY_LEFT=16'h50, KEY_RIGHT=16'h4F, KEY_NONE=16'h0.
- One sub-module, key_repeat: frame-counted repeat FSM. Inputs Clk, Reset, frame_evt, dir_valid, dir, enable. Outputs pulse and pulse_dir.
- The top-level keeps the synchroniser, selection and mux logic.

Test Plan:
- Reset, then keycode=16'h5A → after 2 Clk: active_idx=1, active_onehot=3'b010, sel_valid=1; cur_x=frog_x[1] 1 Clk later. Keycode then 0 → selection held.
- Frog 1 selected, keycode=16'h52 held for 30 frames (REPEAT_DELAY=20, REPEAT_RATE=6) → move_up pulses on frames 1, 21 and 27 only, each 1 Clk wide; last_dir=DIR_UP.
- Frog 1 active, then frog_dead[1]=1 with frog 2 eligible → next cycle active_idx=2. Then frog_dead=3'b111 → sel_valid=0, cur_x=0, cur_y=0, no move pulses on later frames while an arrow is held.
- keycode=16'h59 while frog_home[0]=1 → selection unchanged. keycode=16'h5C (k=3 ≥ NUM_FROGS) → ignored.
- Hold right for 5 frames, switch to left mid-frame → move_left pulses on the next frame_evt; no further move_right.
- Assert Reset during REPEAT with the key still held → all outputs at reset values. After Reset drops and frog 0 is selected, the first pulse arrives on the first frame_evt, the repeat starting REPEAT_DELAY frames later.

Source files
------------

// File: rtl/frogger_pkg.sv
// Shared types and keycodes for the frog selection / arrow-key control hub.
package frogger_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  localparam logic [15:0] KEY_UP    = 16'h52;
  localparam logic [15:0] KEY_DOWN  = 16'h51;
  localparam logic [15:0] KEY_LEFT  = 16'h50;
  localparam logic [15:0] KEY_RIGHT = 16'h4F;
  localparam logic [15:0] KEY_NONE  = 16'h0;

endpackage

// File: rtl/frog_control_hub_key_repeat.sv
// Frame-counted press-and-hold repeat FSM: one pulse on press, then after
// REPEAT_DELAY frames, then every REPEAT_RATE frames until release.
module key_repeat
  import frogger_pkg::*;
#(
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 6
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_evt,
  input  logic       dir_valid,
  input  logic [1:0] dir,
  input  logic       enable,
  output logic       pulse,
  output logic [1:0] pulse_dir
);

  localparam int RATE    = (REPEAT_RATE < 1) ? 1 : REPEAT_RATE;
  localparam int CNT_MAX = (REPEAT_DELAY > RATE) ? REPEAT_DELAY : RATE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DELAY_LOAD = (REPEAT_DELAY > 0) ? CNT_W'(REPEAT_DELAY - 1) : '0;
  localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(RATE - 1);

  rpt_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       held_dir;
  logic             released;

  // Release or a change of direction drops straight back to IDLE, frame or not.
  assign released = !dir_valid || (dir != held_dir);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      held_dir  <= DIR_UP;
      pulse     <= 1'b0;
      pulse_dir <= DIR_UP;
    end else begin
      pulse <= 1'b0;
      if (state != IDLE && released) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (frame_evt && dir_valid && enable) begin
              pulse     <= 1'b1;
              pulse_dir <= dir;
              held_dir  <= dir;
              cnt       <= DELAY_LOAD;
              state     <= DELAY;
            end
          end
          DELAY: begin
            // With REPEAT_DELAY of zero the FSM parks here until release.
            if (frame_evt && REPEAT_DELAY > 0) begin
              if (cnt == '0) begin
                pulse <= enable;
                if (enable) pulse_dir <= held_dir;
                cnt   <= RATE_LOAD;
                state <= REPEAT;
              end else begin
                cnt <= cnt - 1'b1;
              end
            end
          end
          REPEAT: begin
            if (frame_evt) begin
              if (cnt == '0) begin
                pulse <= enable;
                if (enable) pulse_dir <= held_dir;
                cnt   <= RATE_LOAD;
              end else begin
                cnt <= cnt - 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/frog_control_hub.sv
// Top-level frog selection, auto-advance, position mux and arrow-key move pulses
// for NUM_FROGS frogs driven by a USB keycode and the VGA vertical sync.
module frog_control_hub
  import frogger_pkg::*;
#(
  parameter int                NUM_FROGS    = 3,
  parameter int                COORD_W      = 11,
  parameter int                KEY_W        = 16,
  parameter logic [KEY_W-1:0]  SEL_KEY_BASE = KEY_W'(16'h59),
  parameter int                REPEAT_DELAY = 20,
  parameter int                REPEAT_RATE  = 6,
  localparam int               IDX_W        = (NUM_FROGS > 1) ? $clog2(NUM_FROGS) : 1
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         frame_vs,
  input  logic [KEY_W-1:0]             keycode,
  input  logic [NUM_FROGS*COORD_W-1:0] frog_x,
  input  logic [NUM_FROGS*COORD_W-1:0] frog_y,
  input  logic [NUM_FROGS-1:0]         frog_dead,
  input  logic [NUM_FROGS-1:0]         frog_home,
  output logic [NUM_FROGS-1:0]         active_onehot,
  output logic [IDX_W-1:0]             active_idx,
  output logic                         sel_valid,
  output logic [COORD_W-1:0]           cur_x,
  output logic [COORD_W-1:0]           cur_y,
  output logic                         move_up,
  output logic                         move_down,
  output logic                         move_left,
  output logic                         move_right,
  output logic [1:0]                   last_dir
);

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a,
                                                input logic [IDX_W-1:0] b);
    logic [IDX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (IDX_W+1)'(NUM_FROGS)) s = s - (IDX_W+1)'(NUM_FROGS);
    return s[IDX_W-1:0];
  endfunction

  logic             vs_s1, vs_s2, frame_evt;
  logic [KEY_W-1:0] key_q;

  // Input stage: vsync synchroniser and keycode register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vs_s1 <= 1'b0;
      vs_s2 <= 1'b0;
      key_q <= '0;
    end else begin
      vs_s1 <= frame_vs;
      vs_s2 <= vs_s1;
      key_q <= keycode;
    end
  end

  assign frame_evt = vs_s1 & ~vs_s2;

  logic [NUM_FROGS-1:0]   eligible, elig_rot;
  logic [2*NUM_FROGS-1:0] elig_dbl;
  logic                   sel_hit, adv_found;
  logic [IDX_W-1:0]       sel_idx, adv_ofs;

  assign eligible = ~(frog_dead | frog_home);
  assign elig_dbl = {eligible, eligible};
  // Bit j of elig_rot is the eligibility of frog (active_idx + j) mod NUM_FROGS.
  assign elig_rot = NUM_FROGS'(elig_dbl >> active_idx);

  always_comb begin
    sel_hit = 1'b0;
    sel_idx = '0;
    for (int k = 0; k < NUM_FROGS; k++) begin
      if (key_q == SEL_KEY_BASE + KEY_W'(k) && eligible[k]) begin
        sel_hit = 1'b1;
        sel_idx = IDX_W'(k);
      end
    end
  end

  always_comb begin
    adv_found = 1'b0;
    adv_ofs   = '0;
    for (int j = NUM_FROGS - 1; j >= 1; j--) begin
      if (elig_rot[j]) begin
        adv_found = 1'b1;
        adv_ofs   = IDX_W'(j);
      end
    end
  end

  // Selection stage: auto-advance off a dead/home frog outranks a select key
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sel_valid  <= 1'b0;
      active_idx <= '0;
    end else if (sel_valid && !elig_rot[0]) begin
      sel_valid <= adv_found;
      if (adv_found) active_idx <= wrap_add(active_idx, adv_ofs);
    end else if (sel_hit) begin
      sel_valid  <= 1'b1;
      active_idx <= sel_idx;
    end
  end

  assign active_onehot = sel_valid ? (NUM_FROGS'(1) << active_idx) : '0;

  logic [COORD_W-1:0] mux_x, mux_y;

  always_comb begin
    mux_x = '0;
    mux_y = '0;
    for (int k = 0; k < NUM_FROGS; k++) begin
      if (active_idx == IDX_W'(k)) begin
        mux_x = frog_x[k*COORD_W +: COORD_W];
        mux_y = frog_y[k*COORD_W +: COORD_W];
      end
    end
  end

  // Position stage: one cycle behind the selection
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cur_x <= '0;
      cur_y <= '0;
    end else if (sel_valid) begin
      cur_x <= mux_x;
      cur_y <= mux_y;
    end else begin
      cur_x <= '0;
      cur_y <= '0;
    end
  end

  logic       dir_valid;
  logic [1:0] dir;

  always_comb begin
    dir_valid = 1'b1;
    dir       = DIR_UP;
    case (key_q)
      KEY_W'(KEY_UP):    dir = DIR_UP;
      KEY_W'(KEY_DOWN):  dir = DIR_DOWN;
      KEY_W'(KEY_LEFT):  dir = DIR_LEFT;
      KEY_W'(KEY_RIGHT): dir = DIR_RIGHT;
      default:           dir_valid = 1'b0;
    endcase
  end

  logic       rpt_pulse;
  logic [1:0] rpt_dir;

  key_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_key_repeat (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_evt (frame_evt),
    .dir_valid (dir_valid),
    .dir       (dir),
    .enable    (sel_valid),
    .pulse     (rpt_pulse),
    .pulse_dir (rpt_dir)
  );

  assign move_up    = rpt_pulse && (rpt_dir == DIR_UP);
  assign move_down  = rpt_pulse && (rpt_dir == DIR_DOWN);
  assign move_left  = rpt_pulse && (rpt_dir == DIR_LEFT);
  assign move_right = rpt_pulse && (rpt_dir == DIR_RIGHT);
  assign last_dir   = rpt_dir;

endmodule

// File: tb/tb_frog_control_hub.sv
// Randomized self-checking bench for frog_control_hub against a frame-level
// reference model of selection, auto-advance and key repeat.
module tb_frog_control_hub;
  import frogger_pkg::*;

  localparam int N  = 3;
  localparam int CW = 11;
  localparam int KW = 16;
  localparam int RD = 20;
  localparam int RR = 6;

  logic            Clk = 1'b0;
  logic            Reset, frame_vs;
  logic [KW-1:0]   keycode;
  logic [N*CW-1:0] frog_x, frog_y;
  logic [N-1:0]    frog_dead, frog_home;
  logic [N-1:0]    active_onehot;
  logic [1:0]      active_idx;
  logic            sel_valid;
  logic [CW-1:0]   cur_x, cur_y;
  logic            move_up, move_down, move_left, move_right;
  logic [1:0]      last_dir;

  frog_control_hub #(
    .NUM_FROGS(N), .COORD_W(CW), .KEY_W(KW), .SEL_KEY_BASE(16'h59),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_vs(frame_vs), .keycode(keycode),
    .frog_x(frog_x), .frog_y(frog_y), .frog_dead(frog_dead), .frog_home(frog_home),
    .active_onehot(active_onehot), .active_idx(active_idx), .sel_valid(sel_valid),
    .cur_x(cur_x), .cur_y(cur_y), .move_up(move_up), .move_down(move_down),
    .move_left(move_left), .move_right(move_right), .last_dir(last_dir)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse monitor: per-direction counts, multi-hot and stretched-pulse counts
  wire [3:0]  mv = {move_right, move_left, move_down, move_up};
  int         cnt[4];
  int         n_multi = 0;
  int         n_wide = 0;
  logic [3:0] prev_mv = 4'b0;

  always @(negedge Clk) begin
    for (int i = 0; i < 4; i++) if (mv[i] === 1'b1) cnt[i] <= cnt[i] + 1;
    if ($countones(mv) > 1) n_multi <= n_multi + 1;
    if ((mv & prev_mv) != 4'b0) n_wide <= n_wide + 1;
    prev_mv <= mv;
  end

  logic [CW-1:0] fx[N], fy[N];

  function automatic int total_pulses();
    return cnt[0] + cnt[1] + cnt[2] + cnt[3];
  endfunction

  function automatic logic [KW-1:0] dir_code(input int d);
    case (d)
      0:       return 16'h52;
      1:       return 16'h51;
      2:       return 16'h50;
      default: return 16'h4F;
    endcase
  endfunction

  // n-th frame of a continuous hold (1-based): press, then delay, then rate
  function automatic int exp_pulse(input int n);
    if (n == 1) return 1;
    if (RD > 0 && n > RD && ((n - RD - 1) % RR) == 0) return 1;
    return 0;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #2;
  endtask

  task automatic frame();
    frame_vs = 1'b1;
    step(3);
    frame_vs = 1'b0;
    step(5);
  endtask

  task automatic load_coords();
    for (int k = 0; k < N; k++) begin
      fx[k] = CW'($urandom_range(1, 2047));
      fy[k] = CW'($urandom_range(1, 2047));
      frog_x[k*CW +: CW] = fx[k];
      frog_y[k*CW +: CW] = fy[k];
    end
  endtask

  task automatic select_frog(input int k);
    keycode = 16'h59 + KW'(k);
    step(3);
    keycode = 16'h0;
    step(1);
    check_val("sel_idx", 32'(active_idx), 32'(k));
    check_val("sel_cur_x", 32'(cur_x), 32'(fx[k]));
  endtask

  task automatic hold(input int d, input int nfr, input bit en, input string tag);
    int base, others0;
    keycode = dir_code(d);
    step(2);
    others0 = total_pulses() - cnt[d];
    for (int n = 1; n <= nfr; n++) begin
      base = cnt[d];
      frame();
      check_val($sformatf("%s_f%0d", tag, n), 32'(cnt[d] - base), en ? 32'(exp_pulse(n)) : 32'd0);
    end
    check_val({tag, "_other"}, 32'(total_pulses() - cnt[d]), 32'(others0));
  endtask

  initial begin
    int k, nk, d, prev_d, len;
    bit found;
    logic [N-1:0] dm, hm, elig;

    Reset = 1'b1; frame_vs = 1'b0; keycode = '0; frog_dead = '0; frog_home = '0;
    load_coords();
    step(3);
    Reset = 1'b0;
    step(1);
    check_val("rst_onehot", 32'(active_onehot), 32'd0);
    check_val("rst_idx", 32'(active_idx), 32'd0);
    check_val("rst_sel", 32'(sel_valid), 32'd0);
    check_val("rst_cur_x", 32'(cur_x), 32'd0);
    check_val("rst_cur_y", 32'(cur_y), 32'd0);
    check_val("rst_moves", 32'(mv), 32'd0);
    check_val("rst_last_dir", 32'(last_dir), 32'(DIR_UP));

    // Select frog 1: two-cycle latency, position one cycle later
    keycode = 16'h5A;
    step(1);
    check_val("sel_lat1", 32'(sel_valid), 32'd0);
    step(1);
    check_val("sel1_idx", 32'(active_idx), 32'd1);
    check_val("sel1_onehot", 32'(active_onehot), 32'b010);
    check_val("sel1_valid", 32'(sel_valid), 32'd1);
    step(1);
    check_val("sel1_cur_x", 32'(cur_x), 32'(fx[1]));
    check_val("sel1_cur_y", 32'(cur_y), 32'(fy[1]));
    keycode = 16'h0;
    step(4);
    check_val("sel1_held", 32'(active_idx), 32'd1);
    check_val("sel1_held_valid", 32'(sel_valid), 32'd1);

    hold(0, 30, 1'b1, "up30");
    check_val("up30_last_dir", 32'(last_dir), 32'(DIR_UP));
    keycode = 16'h0;
    step(2);

    // Ineligible and out-of-range selects are ignored
    frog_home[0] = 1'b1;
    keycode = 16'h59;
    step(3);
    check_val("home_sel_ignored", 32'(active_idx), 32'd1);
    keycode = 16'h5C;
    step(3);
    check_val("range_sel_ignored", 32'(active_idx), 32'd1);
    check_val("range_sel_valid", 32'(sel_valid), 32'd1);
    keycode = 16'h0;
    frog_home = '0;
    step(1);

    // Right held, then switched to left without release
    hold(3, 5, 1'b1, "right5");
    hold(2, 3, 1'b1, "left_after_right");
    check_val("switch_last_dir", 32'(last_dir), 32'(DIR_LEFT));
    keycode = 16'h0;
    step(2);

    // Auto-advance outranks a select key sampled in the same cycle
    select_frog(0);
    keycode = 16'h5B;
    step(1);
    frog_dead[0] = 1'b1;
    step(1);
    check_val("adv_prio_idx", 32'(active_idx), 32'd1);
    step(1);
    check_val("adv_then_sel_idx", 32'(active_idx), 32'd2);
    keycode = 16'h0;
    frog_dead = '0;
    step(1);

    // Frog 1 dies -> frog 2; all dead -> nothing selected, no moves
    select_frog(1);
    frog_dead[1] = 1'b1;
    step(1);
    check_val("dead1_idx", 32'(active_idx), 32'd2);
    check_val("dead1_onehot", 32'(active_onehot), 32'b100);
    step(1);
    check_val("dead1_cur_x", 32'(cur_x), 32'(fx[2]));
    frog_dead = 3'b111;
    step(1);
    check_val("alldead_sel", 32'(sel_valid), 32'd0);
    check_val("alldead_onehot", 32'(active_onehot), 32'd0);
    step(1);
    check_val("alldead_cur_x", 32'(cur_x), 32'd0);
    check_val("alldead_cur_y", 32'(cur_y), 32'd0);
    hold(0, 3, 1'b0, "alldead_up");
    keycode = 16'h0;
    frog_dead = '0;
    step(2);

    // Randomized auto-advance against next-eligible search
    for (int it = 0; it < 10; it++) begin
      frog_dead = '0;
      frog_home = '0;
      k = $urandom_range(0, N - 1);
      select_frog(k);
      dm = N'($urandom_range(0, 7));
      hm = N'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) dm = dm | (N'(1) << k);
      else hm = hm | (N'(1) << k);
      elig = ~(dm | hm);
      found = 1'b0;
      nk = 0;
      for (int j = 1; j < N; j++) begin
        if (!found && ((elig >> ((k + j) % N)) & N'(1)) != '0) begin
          found = 1'b1;
          nk = (k + j) % N;
        end
      end
      frog_dead = dm;
      frog_home = hm;
      step(1);
      check_val("radv_sel", 32'(sel_valid), 32'(found));
      check_val("radv_onehot", 32'(active_onehot), found ? (32'd1 << nk) : 32'd0);
      step(1);
    end
    frog_dead = '0;
    frog_home = '0;
    step(1);

    // Randomized holds, direction switches and reselects
    load_coords();
    select_frog($urandom_range(0, N - 1));
    prev_d = -1;
    for (int it = 0; it < 8; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          load_coords();
          select_frog($urandom_range(0, N - 1));
          d = $urandom_range(0, 3);
        end
        1: begin
          keycode = 16'h0;
          step(2);
          d = $urandom_range(0, 3);
        end
        default: begin
          d = $urandom_range(0, 3);
          if (d == prev_d) d = (d + 1 + $urandom_range(0, 2)) % 4;
        end
      endcase
      len = $urandom_range(1, 35);
      hold(d, len, 1'b1, $sformatf("rhold%0d", it));
      check_val("rhold_last_dir", 32'(last_dir), 32'(d));
      prev_d = d;
    end
    keycode = 16'h0;
    step(2);

    // Reset while repeating with the key still held
    select_frog(0);
    hold(3, 25, 1'b1, "pre_reset_right");
    Reset = 1'b1;
    step(1);
    check_val("mrst_sel", 32'(sel_valid), 32'd0);
    check_val("mrst_idx", 32'(active_idx), 32'd0);
    check_val("mrst_onehot", 32'(active_onehot), 32'd0);
    check_val("mrst_cur_x", 32'(cur_x), 32'd0);
    check_val("mrst_cur_y", 32'(cur_y), 32'd0);
    check_val("mrst_moves", 32'(mv), 32'd0);
    check_val("mrst_last_dir", 32'(last_dir), 32'(DIR_UP));
    step(1);
    Reset = 1'b0;
    hold(3, 2, 1'b0, "post_reset_nosel");
    keycode = 16'h0;
    step(2);
    select_frog(0);
    hold(0, 28, 1'b1, "post_reset_up");
    keycode = 16'h0;
    step(2);

    check_val("multi_hot_pulses", 32'(n_multi), 32'd0);
    check_val("wide_pulses", 32'(n_wide), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
